// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the FloatingSqrt arbiter slice.
// FSQRT_ARB_NEG_FLAG_EN adds the negative-operand flag to the response entry.
package fsqrt_pkg;

  localparam int unsigned FP_W    = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;
  localparam int unsigned ID_MAXW = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } arb_state_e;

  typedef struct packed {
    logic [FP_W-1:0]    data;
    logic [ID_MAXW-1:0] id;
`ifdef FSQRT_ARB_NEG_FLAG_EN
    logic               neg;
`endif
  } rsp_entry_t;

  function automatic logic is_neg_nonzero(input logic [FP_W-1:0] a);
    return a[FP_W-1] & (|a[FP_W-2:0]);
  endfunction

endpackage

// File: rtl/fsqrt_arbiter_if.sv
// Requester, sqrt-unit and response signals of the fsqrt arbiter.
// master = arbiter side, slave = surrounding FPU/sqrt-unit side.
interface fsqrt_arbiter_if
  import fsqrt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [FP_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [FP_W-1:0]      sq_a;
  logic                 sq_en;
  logic [FP_W-1:0]      sq_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [FP_W-1:0]      rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_neg;
  logic                 flush_req;
  logic                 flush_done;

  modport master (
    input  req_valid, req_data, sq_out, rsp_ready, flush_req,
    output req_ready, sq_a, sq_en, rsp_valid, rsp_data, rsp_id, rsp_neg, flush_done
  );

  modport slave (
    output req_valid, req_data, sq_out, rsp_ready, flush_req,
    input  req_ready, sq_a, sq_en, rsp_valid, rsp_data, rsp_id, rsp_neg, flush_done
  );
endinterface

// File: rtl/fsqrt_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head is shown combinationally.
module fsqrt_rsp_fifo
  import fsqrt_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_i,
  input  rsp_entry_t    push_data_i,
  input  logic          pop_i,
  output rsp_entry_t    head_o,
  output logic [CW-1:0] count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (do_pop) rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Credit accounting upstream must make this unreachable.
  assert property (@(posedge CLK) disable iff (!RST)
    !(push_i && (count_q == CW'(DEPTH)) && !do_pop));

endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one FloatingSqrt unit among NREQ requesters.
// Optional macro: FSQRT_ARB_NEG_FLAG_EN (negative-operand flag, qNaN result).
module fsqrt_arbiter
  import fsqrt_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input logic            CLK,
  input logic            RST,
  fsqrt_arbiter_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            active_q;
  logic [FP_W-1:0] sq_a_q;
  logic [LAT:0]    tag_v_q;
  logic [IDW-1:0]  tag_id_q [LAT+1];
`ifdef FSQRT_ARB_NEG_FLAG_EN
  logic [LAT:0]    tag_neg_q;
`endif

  logic            gnt_found, credit_ok, fire;
  logic [IDW-1:0]  gnt_id;
  logic [FP_W-1:0] gnt_op;
  int unsigned     inflight;
  logic [CW-1:0]   fifo_count;
  rsp_entry_t      push_entry, head;
  logic            push, pop, rsp_valid;

  // First valid requester at or after rr_q, modulo NREQ.
  always_comb begin
    logic [IDW-1:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_q) + i) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign inflight  = $countones(tag_v_q);
  assign credit_ok = (inflight + 32'(fifo_count)) < DEPTH;
  assign fire      = active_q && (state_q == ST_RUN) && credit_ok && gnt_found;
  assign gnt_op    = bus.req_data[FP_W*gnt_id +: FP_W];
  assign rr_d      = !fire ? rr_q : (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  assign bus.req_ready = fire ? (NREQ'(1) << gnt_id) : '0;
  assign bus.sq_a      = sq_a_q;
  assign bus.sq_en     = active_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_RUN;
      rr_q     <= '0;
      active_q <= 1'b0;
      sq_a_q   <= '0;
      tag_v_q  <= '0;
      for (int unsigned s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
`ifdef FSQRT_ARB_NEG_FLAG_EN
      tag_neg_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      active_q <= 1'b1;
      if (fire) sq_a_q <= gnt_op;
      tag_v_q     <= {tag_v_q[LAT-1:0], fire};
      tag_id_q[0] <= gnt_id;
      for (int unsigned s = 1; s <= LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
`ifdef FSQRT_ARB_NEG_FLAG_EN
      tag_neg_q <= {tag_neg_q[LAT-1:0], is_neg_nonzero(gnt_op)};
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.flush_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.flush_req) state_d = ST_RUN;
        else if (inflight == 0 && fifo_count == '0) state_d = ST_DONE;
      end
      ST_DONE:  if (!bus.flush_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Last tag stage lines up with the sqrt unit's registered output.
  assign push = tag_v_q[LAT];
  always_comb begin
    push_entry    = '0;
    push_entry.id = ID_MAXW'(tag_id_q[LAT]);
`ifdef FSQRT_ARB_NEG_FLAG_EN
    push_entry.neg  = tag_neg_q[LAT];
    push_entry.data = tag_neg_q[LAT] ? FP_QNAN : bus.sq_out;
`else
    push_entry.data = bus.sq_out;
`endif
  end

  fsqrt_rsp_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign rsp_valid      = (fifo_count != '0);
  assign pop            = rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_valid ? head.data : '0;
  assign bus.rsp_id     = rsp_valid ? IDW'(head.id) : '0;
`ifdef FSQRT_ARB_NEG_FLAG_EN
  assign bus.rsp_neg    = rsp_valid & head.neg;
`else
  assign bus.rsp_neg    = 1'b0;
`endif
  assign bus.flush_done = (state_q == ST_DONE) && bus.flush_req;

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Scoreboard bench for fsqrt_arbiter: a LUT-based sqrt unit model, a transfer
// monitor pushing expected responses and a response monitor checking them.
module tb_fsqrt_arbiter;
  import fsqrt_pkg::*;

  localparam int unsigned NREQ = 4, LAT = 1, DEPTH = 4, IDW = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fsqrt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fsqrt_arbiter #(
    .NREQ  (NREQ),
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           neg;
  } exp_t;

  exp_t        sb_q[$];
  int          gnt_log[$];
  int          checks = 0, failures = 0;
  int          xfers = 0, rsps = 0;
  logic [31:0] mon_op;
  exp_t        mon_e;

  function automatic logic [31:0] sqrt_lut(input logic [31:0] a);
    case (a)
      32'h40800000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'h41800000: return 32'h40800000;
      32'h41100000: return 32'h40400000;
      32'h3E800000: return 32'h3F000000;
      32'h42800000: return 32'h41000000;
      32'h42C80000: return 32'h41200000;
      32'h40100000: return 32'h3FC00000;
      32'h00000000: return 32'h00000000;
      32'h80000000: return 32'h80000000;
      default:      return 32'h7FC00000;
    endcase
  endfunction

  function automatic logic exp_neg(input logic [31:0] a);
`ifdef FSQRT_ARB_NEG_FLAG_EN
    return a[31] & (|a[30:0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return exp_neg(a) ? 32'h7FC00000 : sqrt_lut(a);
  endfunction

  // Sqrt unit model: one registered stage, output zeroed while EN is low.
  always @(posedge CLK) bus.sq_out <= bus.sq_en ? sqrt_lut(bus.sq_a) : 32'h0;

  always @(negedge CLK) begin
    if (RST) begin
      checks++;
      if (!$onehot0(bus.req_ready)) begin
        failures++;
        $display("FAIL req_ready_onehot: got %b required at most one bit", bus.req_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_op = bus.req_data[32*i +: 32];
          sb_q.push_back('{data: exp_data(mon_op), id: IDW'(i), neg: exp_neg(mon_op)});
          gnt_log.push_back(i);
          xfers++;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        rsps++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got data=%h id=%0d with nothing outstanding",
                   bus.rsp_data, bus.rsp_id);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.rsp_data !== mon_e.data || bus.rsp_id !== mon_e.id || bus.rsp_neg !== mon_e.neg) begin
            failures++;
            $display("FAIL rsp: got data=%h id=%0d neg=%0b required data=%h id=%0d neg=%0b",
                     bus.rsp_data, bus.rsp_id, bus.rsp_neg, mon_e.data, mon_e.id, mon_e.neg);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 0);
    chk({tag, "_sq_a"},       bus.sq_a, 0);
    chk({tag, "_sq_en"},      32'(bus.sq_en), 0);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_data"},   bus.rsp_data, 0);
    chk({tag, "_rsp_id"},     32'(bus.rsp_id), 0);
    chk({tag, "_rsp_neg"},    32'(bus.rsp_neg), 0);
    chk({tag, "_flush_done"}, 32'(bus.flush_done), 0);
  endtask

  task automatic do_reset();
    RST           = 1'b0;
    bus.req_valid = '0;
    bus.flush_req = 1'b0;
    bus.rsp_ready = 1'b0;
    sb_q.delete();
    gnt_log.delete();
    cyc();
    cyc();
    RST = 1'b1;
    cyc();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || bus.rsp_valid) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_timeout: got %0d outstanding required 0", name, sb_q.size());
    end
  endtask

  task automatic set_ops(input logic [31:0] o0, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [31:0] o3);
    bus.req_data = {o3, o2, o1, o0};
  endtask

  logic [31:0] single_ops [6] = '{32'h40800000, 32'h3F800000, 32'h41800000,
                                  32'h00000000, 32'h80000000, 32'hC0800000};

  initial begin
    int x0, r0, r;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.flush_req = 1'b0;
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_vals("por");
    cyc();
    RST = 1'b1;
    cyc();
    @(negedge CLK);
    chk("sq_en_after_release", 32'(bus.sq_en), 1);

    // Single requests, one at a time, with latency check on the first.
    cyc();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r = k % NREQ;
      bus.req_data = '0;
      bus.req_data[32*r +: 32] = single_ops[k];
      bus.req_valid = NREQ'(1) << r;
      @(negedge CLK);
      chk("single_grant", 32'(bus.req_ready), 32'(1) << r);
      cyc();
      bus.req_valid = '0;
      if (k == 0) begin
        for (int c = 0; c <= LAT; c++) begin
          @(negedge CLK);
          chk("latency_not_yet", 32'(bus.rsp_valid), 0);
          cyc();
        end
        @(negedge CLK);
        chk("latency_valid", 32'(bus.rsp_valid), 1);
      end
      wait_drain("single");
    end

    // Round robin with all requesters valid.
    do_reset();
    bus.rsp_ready = 1'b1;
    set_ops(32'h42800000, 32'h42C80000, 32'h41100000, 32'h3E800000);
    bus.req_valid = '1;
    for (int n = 0; n < 100 && gnt_log.size() < 8; n++) cyc();
    bus.req_valid = '0;
    chk("rr_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], i % NREQ);
    wait_drain("rr");

    // Backpressure: exactly DEPTH transfers while responses are held.
    do_reset();
    x0 = xfers;
    r0 = rsps;
    set_ops(32'h40100000, 32'h3F800000, 32'h40800000, 32'h41800000);
    bus.req_valid = '1;
    repeat (10) cyc();
    @(negedge CLK);
    chk("bp_accepted", xfers - x0, DEPTH);
    chk("bp_ready_blocked", 32'(bus.req_ready), 0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_ready_same_cycle_as_pop", 32'(bus.req_ready), 0);
    cyc();
    bus.rsp_ready = 1'b0;
    @(negedge CLK);
    chk("bp_ready_after_pop", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_drain("bp");
    chk("bp_total_xfers", xfers - x0, DEPTH + 1);
    chk("bp_no_loss", rsps - r0, DEPTH + 1);

    // Flush with two operations in flight.
    do_reset();
    x0 = xfers;
    set_ops(32'h41100000, 32'h3E800000, 32'h42800000, 32'h42C80000);
    bus.req_valid = 4'b0011;
    cyc();
    cyc();
    bus.req_valid = '0;
    bus.flush_req = 1'b1;
    cyc();
    bus.req_valid = 4'b0011;
    repeat (4) begin
      @(negedge CLK);
      chk("flush_no_grant", 32'(bus.req_ready), 0);
      chk("flush_done_early", 32'(bus.flush_done), 0);
      cyc();
    end
    chk("flush_inflight_count", xfers - x0, 2);
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("flush_done_last_pop", 32'(bus.flush_done), 0);
    cyc();
    @(negedge CLK);
    chk("flush_done_drained_cycle", 32'(bus.flush_done), 0);
    cyc();
    @(negedge CLK);
    chk("flush_done_high", 32'(bus.flush_done), 1);
    chk("flush_done_no_grant", 32'(bus.req_ready), 0);
    cyc();
    bus.flush_req = 1'b0;
    @(negedge CLK);
    chk("flush_done_drop", 32'(bus.flush_done), 0);
    chk("flush_exit_no_grant", 32'(bus.req_ready), 0);
    cyc();
    @(negedge CLK);
    chk("flush_resume_grant", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    wait_drain("flush");
    chk("flush_total_xfers", xfers - x0, 3);

    // Reset while three operations are outstanding.
    do_reset();
    x0 = xfers;
    set_ops(32'h40800000, 32'h41800000, 32'h3F800000, 32'h00000000);
    bus.req_valid = 4'b0111;
    cyc();
    cyc();
    cyc();
    bus.req_valid = '0;
    chk("midrst_issued", xfers - x0, 3);
    RST = 1'b0;
    sb_q.delete();
    @(negedge CLK);
    check_reset_vals("midrst");
    cyc();
    RST = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk("midrst_no_stale", 32'(bus.rsp_valid), 0);
      cyc();
    end
    set_ops(32'h40800000, 32'h0, 32'h0, 32'h0);
    bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = '0;
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
